// File: rtl/button_pkg.sv
// Shared definitions for the button gesture classifier: state encoding and
// default timing constants for the 100 MHz board clock.
package button_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t PRESS1    = 3'd1;
    localparam state_t GAP       = 3'd2;
    localparam state_t PRESS2    = 3'd3;
    localparam state_t LONG_HOLD = 3'd4;

    localparam int unsigned DEF_LONG_CYC   = 32'd50_000_000;
    localparam int unsigned DEF_DBL_CYC    = 32'd25_000_000;
    localparam int unsigned DEF_REPEAT_CYC = 32'd10_000_000;
    localparam int unsigned DEF_CW         = 32'd26;

endpackage

// File: rtl/gesture_timer.sv
// Shared down-counter for press and gap timing: load wins over decrement,
// and decrement saturates at zero so the counter never wraps.
module gesture_timer
    import button_pkg::*;
#(
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          q_zero
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next counter value: load, saturating decrement, or hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q_zero = (count_q == '0);

endmodule

// File: rtl/button_gesture.sv
// Classifies debounced presses into single, double and long gestures with
// one-cycle registered pulses. Define GESTURE_REPEAT_EN for long-press auto-repeat.
module button_gesture
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYC   = DEF_LONG_CYC,
    parameter int unsigned DBL_CYC    = DEF_DBL_CYC,
    parameter int unsigned REPEAT_CYC = DEF_REPEAT_CYC,
    parameter int unsigned CW         = DEF_CW
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic single_tick,
    output logic double_tick,
    output logic long_tick,
    output logic busy
);

    localparam logic [CW-1:0] LONG_LOAD   = CW'(LONG_CYC - 32'd1);
    localparam logic [CW-1:0] DBL_LOAD    = CW'(DBL_CYC - 32'd1);
    localparam logic [CW-1:0] REPEAT_LOAD = CW'(REPEAT_CYC - 32'd1);

    state_t        state_q;
    state_t        state_d;
    logic          single_q;
    logic          single_d;
    logic          double_q;
    logic          double_d;
    logic          long_q;
    logic          long_d;
    logic          tmr_load;
    logic [CW-1:0] tmr_load_val;
    logic          tmr_dec;
    logic          tmr_zero;

    gesture_timer #(
        .CW(CW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .dec     (tmr_dec),
        .q_zero  (tmr_zero)
    );

    // State and tick registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
        end
    end

    // Next-state logic; a second press in GAP beats the gap timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (btn_level) state_d = PRESS1;
                else           state_d = IDLE;
            end
            PRESS1: begin
                if (!btn_level)    state_d = GAP;
                else if (tmr_zero) state_d = LONG_HOLD;
                else               state_d = PRESS1;
            end
            GAP: begin
                if (btn_level)     state_d = PRESS2;
                else if (tmr_zero) state_d = IDLE;
                else               state_d = GAP;
            end
            PRESS2: begin
                if (!btn_level) state_d = IDLE;
                else            state_d = PRESS2;
            end
            LONG_HOLD: begin
                if (!btn_level) state_d = IDLE;
                else            state_d = LONG_HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer control and next tick values; load_val idles at the repeat reload.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = REPEAT_LOAD;
        tmr_dec      = 1'b0;
        single_d     = 1'b0;
        double_d     = 1'b0;
        long_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_level) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = LONG_LOAD;
                end else begin
                    tmr_load     = 1'b0;
                end
            end
            PRESS1: begin
                if (!btn_level) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = DBL_LOAD;
                end else if (tmr_zero) begin
                    long_d       = 1'b1;
`ifdef GESTURE_REPEAT_EN
                    tmr_load     = 1'b1;
                    tmr_load_val = REPEAT_LOAD;
`endif
                end else begin
                    tmr_dec      = 1'b1;
                end
            end
            GAP: begin
                if (btn_level) begin
                    tmr_dec  = 1'b0;
                end else if (tmr_zero) begin
                    single_d = 1'b1;
                end else begin
                    tmr_dec  = 1'b1;
                end
            end
            PRESS2: begin
                if (!btn_level) double_d = 1'b1;
                else            double_d = 1'b0;
            end
            LONG_HOLD: begin
`ifdef GESTURE_REPEAT_EN
                if (btn_level && tmr_zero) begin
                    long_d       = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = REPEAT_LOAD;
                end else if (btn_level) begin
                    tmr_dec      = 1'b1;
                end else begin
                    tmr_dec      = 1'b0;
                end
`else
                tmr_dec = 1'b0;
`endif
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        busy        = (state_q != IDLE);
        single_tick = single_q;
        double_tick = double_q;
        long_tick   = long_q;
    end

endmodule

// File: tb/tb_button_gesture.sv
// Self-checking bench for button_gesture: expectations come from gesture
// durations (press length, gap length) rather than from a state machine.
module tb_button_gesture;

    localparam int L  = 20;
    localparam int D  = 10;
    localparam int R  = 5;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset;
    logic btn_level;
    logic single_tick;
    logic double_tick;
    logic long_tick;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-edge stimulus and expected outputs (index = edge number in the run).
    bit lv[$];
    bit es[$];
    bit ed[$];
    bit el[$];
    bit eb[$];

    button_gesture #(
        .LONG_CYC  (L),
        .DBL_CYC   (D),
        .REPEAT_CYC(R),
        .CW        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_level  (btn_level),
        .single_tick(single_tick),
        .double_tick(double_tick),
        .long_tick  (long_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp, input int idx);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %b expected %b", tag, idx, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx,
                             input bit xs, input bit xd, input bit xl, input bit xb);
        check({tag, ".single"}, single_tick, xs, idx);
        check({tag, ".double"}, double_tick, xd, idx);
        check({tag, ".long"},   long_tick,   xl, idx);
        check({tag, ".busy"},   busy,        xb, idx);
    endtask

    task automatic push_lvl(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            lv.push_back(b);
            es.push_back(1'b0);
            ed.push_back(1'b0);
            el.push_back(1'b0);
            eb.push_back(1'b0);
        end
    endtask

    // One gesture: h1 high samples, then g low, then h2 high (h2 = 0: none), then idle low.
    task automatic add_gesture(input int h1, input int g, input int h2, input int idle);
        int s;
        int end_e;
        int lows;
        s = lv.size();
        push_lvl(1'b1, h1);
        if (h1 >= L + 1) begin
            el[s + L] = 1'b1;
`ifdef GESTURE_REPEAT_EN
            for (int k = 1; L + k * R <= h1 - 1; k++) el[s + L + k * R] = 1'b1;
`endif
            end_e = s + h1;
            push_lvl(1'b0, (idle < 1) ? 1 : idle);
        end else if (h2 > 0 && g <= D) begin
            push_lvl(1'b0, g);
            push_lvl(1'b1, h2);
            end_e = s + h1 + g + h2;
            push_lvl(1'b0, (idle < 1) ? 1 : idle);
            ed[end_e] = 1'b1;
        end else begin
            lows = (g > D) ? g : D + 1;
            push_lvl(1'b0, lows + idle);
            end_e = s + h1 + D;
            es[end_e] = 1'b1;
        end
        for (int e = s; e < end_e; e++) eb[e] = 1'b1;
    endtask

    task automatic play(input string tag);
        for (int i = 0; i < lv.size(); i++) begin
            btn_level = lv[i];
            @(posedge clk);
            #1;
            check_all(tag, i, es[i], ed[i], el[i], eb[i]);
        end
        lv.delete(); es.delete(); ed.delete(); el.delete(); eb.delete();
    endtask

    initial begin
        reset     = 1'b1;
        btn_level = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_held", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Button already held when reset releases.
        add_gesture(25, 0, 0, 3);
        play("held_at_reset");

        add_gesture(5, 15, 0, 0);
        play("single");

        add_gesture(5, 4, 3, 3);
        play("double");

        add_gesture(30, 0, 0, 3);
        play("long");

        add_gesture(5, 10, 3, 3);
        play("gap_boundary");

        add_gesture(5, 11, 0, 2);
        play("gap_just_late");

        add_gesture(20, 5, 0, 2);
        play("press_eq_long");

        add_gesture(21, 0, 0, 2);
        play("press_long_min");

        add_gesture(3, 2, 30, 2);
        play("held_second_press");

        // Reset partway through PRESS1 aborts the gesture without a pulse.
        push_lvl(1'b1, 10);
        for (int i = 0; i < 10; i++) eb[i] = 1'b1;
        play("pre_abort");
        reset = 1'b1;
        #1;
        check_all("abort_async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all("abort_held", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        add_gesture(25, 0, 0, 3);
        play("after_abort");

        for (int n = 0; n < 40; n++) begin
            int h1;
            int g;
            int h2;
            int idle;
            h1   = $urandom_range(1, 28);
            g    = $urandom_range(1, 14);
            h2   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
            idle = $urandom_range(1, 4);
            add_gesture(h1, g, h2, idle);
        end
        play("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
